// File: rtl/lu_probe.sv
// Self-identification engine for a 2-input, 8-operation logic unit: sweeps a/b, captures the
// truth table and decodes it to a select code. `LU_PROBE_EXPECT_EN adds expect_code/match.
module lu_probe #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef LU_PROBE_EXPECT_EN
  input  logic [2:0] expect_code,
  output logic       match,
`endif
  input  logic       lu_result,
  output logic       probe_a,
  output logic       probe_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [2:0] op_code,
  output logic       op_valid
);

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StDecode, StDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q;
  logic [3:0] cnt_q;
  logic [3:0] shadow_q;
  logic [3:0] tt_q;
  logic [2:0] op_q;
  logic       valid_q;
  logic [2:0] dec_op;
  logic       dec_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StDrive;
      StDrive:  if (cnt_q == 4'd0 && idx_q == 2'd3) state_d = StDecode;
      StDecode: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= 2'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 4'd0;
      tt_q     <= 4'd0;
      op_q     <= 3'd0;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            idx_q <= 2'd0;
            cnt_q <= SettleLoad;
          end
        end
        StDrive: begin
          if (cnt_q == 4'd0) begin
            shadow_q[idx_q] <= lu_result;
            if (idx_q != 2'd3) begin
              idx_q <= idx_q + 2'd1;
              cnt_q <= SettleLoad;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDecode: begin
          tt_q    <= shadow_q;
          op_q    <= dec_op;
          valid_q <= dec_valid;
        end
        default: ;
      endcase
    end
  end

`ifdef LU_PROBE_EXPECT_EN
  logic [2:0] expect_q;
  logic       match_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expect_q <= 3'd0;
      match_q  <= 1'b0;
    end else begin
      if (state_q == StIdle && start) expect_q <= expect_code;
      if (state_q == StDecode) match_q <= dec_valid && (dec_op == expect_q);
    end
  end

  assign match = match_q;
`endif

  // Truth table bit index is {a,b}; anything outside the eight operations is invalid.
  always_comb begin
    dec_op    = 3'd0;
    dec_valid = 1'b1;
    case (shadow_q)
      4'b0011: dec_op = 3'd0;
      4'b0101: dec_op = 3'd1;
      4'b1000: dec_op = 3'd2;
      4'b0111: dec_op = 3'd3;
      4'b1110: dec_op = 3'd4;
      4'b0001: dec_op = 3'd5;
      4'b0110: dec_op = 3'd6;
      4'b1001: dec_op = 3'd7;
      default: dec_valid = 1'b0;
    endcase
  end

  always_comb begin
    probe_a     = (state_q == StDrive) & idx_q[1];
    probe_b     = (state_q == StDrive) & idx_q[0];
    busy        = (state_q == StDrive) || (state_q == StDecode);
    done        = (state_q == StDone);
    truth_table = tt_q;
    op_code     = op_q;
    op_valid    = valid_q;
  end

endmodule
